// File: rtl/dual_issue_scheduler.sv
// In-order pairing scheduler: circular descriptor queue feeding two issue slots.
// Build macro DUAL_ISSUE_EN enables pairing; without it one instruction issues per cycle.
module dual_issue_scheduler #(
  parameter int  DEPTH     = 8,
  parameter int  PAYLOAD_W = 32,
  localparam int ENTRY_W   = PAYLOAD_W + 18,
  localparam int CW        = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr0,
  input  logic               wr1,
  input  logic [ENTRY_W-1:0] in0,
  input  logic [ENTRY_W-1:0] in1,
  output logic               in_ready,
  input  logic               stall,
  input  logic               flush,
  output logic               iss1_valid,
  output logic [ENTRY_W-1:0] iss1,
  output logic               iss2_valid,
  output logic [ENTRY_W-1:0] iss2,
  output logic [CW-1:0]      count
);

  localparam int PW = $clog2(DEPTH);

  // Handshake: upstream may write (wr0, optionally wr1) in any cycle; a write is
  // taken only when in_ready was 1 before the edge and flush is low, otherwise it
  // is silently dropped. Downstream consumes whatever sits in iss* whenever stall=0.

  logic [PW-1:0]      head, tail, head_p1, tail_p1;
  logic [CW-1:0]      count_q;
  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] ent_a, ent_b;
  logic               has_a, pair_ok;
  logic               wr_acc, wr_two;
  logic               issue_one, issue_two;
  logic [CW-1:0]      n_wr, n_iss;

  assign head_p1 = head + PW'(1);
  assign tail_p1 = tail + PW'(1);
  assign ent_a   = mem_q[head];
  assign ent_b   = mem_q[head_p1];
  assign has_a   = (count_q != '0);

  assign in_ready = (count_q <= CW'(DEPTH - 2));
  assign count    = count_q;

`ifdef DUAL_ISSUE_EN
  logic       a_we, b_we, a_mem, b_mem, a_br, has_b;
  logic [4:0] a_rd, b_rd, b_rs, b_rt;
  logic       raw_hz, waw_hz, str_hz;

  assign a_br  = ent_a[17];
  assign a_mem = ent_a[16];
  assign a_we  = ent_a[15];
  assign a_rd  = ent_a[14:10];
  assign b_mem = ent_b[16];
  assign b_we  = ent_b[15];
  assign b_rd  = ent_b[14:10];
  assign b_rs  = ent_b[9:5];
  assign b_rt  = ent_b[4:0];
  assign has_b = (count_q >= CW'(2));

  assign raw_hz  = a_we && (a_rd != 5'd0) && ((a_rd == b_rs) || (a_rd == b_rt));
  assign waw_hz  = a_we && b_we && (a_rd == b_rd) && (a_rd != 5'd0);
  assign str_hz  = a_mem && b_mem;
  // A branch in the older slot holds B back until its outcome is known.
  assign pair_ok = has_b && !raw_hz && !waw_hz && !str_hz && !a_br;
`else
  assign pair_ok = 1'b0;
`endif

  assign wr_acc    = in_ready && !flush && wr0;
  assign wr_two    = wr_acc && wr1;
  assign issue_one = !stall && has_a;
  assign issue_two = issue_one && pair_ok;
  assign n_wr      = CW'(wr_acc) + CW'(wr_two);
  assign n_iss     = CW'(issue_one) + CW'(issue_two);

  // Storage needs no reset: occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[tail] <= in0;
    if (wr_two) mem_q[tail_p1] <= in1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head       <= '0;
      tail       <= '0;
      count_q    <= '0;
      iss1_valid <= 1'b0;
      iss1       <= '0;
      iss2_valid <= 1'b0;
      iss2       <= '0;
    end else if (flush) begin
      head       <= '0;
      tail       <= '0;
      count_q    <= '0;
      iss1_valid <= 1'b0;
      iss1       <= '0;
      iss2_valid <= 1'b0;
      iss2       <= '0;
    end else begin
      head    <= head + PW'(n_iss);
      tail    <= tail + PW'(n_wr);
      count_q <= count_q + n_wr - n_iss;
      if (!stall) begin
        iss1_valid <= has_a;
        iss1       <= has_a ? ent_a : '0;
        iss2_valid <= issue_two;
        iss2       <= issue_two ? ent_b : '0;
      end
    end
  end

endmodule
